// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
`ifndef FCLK
`define FCLK 1_600_000
`endif

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_state_t;

  // Clocks per bit at a given line rate.
  function automatic int unsigned nticks(input int unsigned fclk, input int unsigned bauds);
    return fclk / bauds;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, byte handshake and status out.
interface uart_rx_if #(
  parameter int unsigned Wdata = 8
);
  logic             RXD;
  logic             ACK;
  logic [Wdata-1:0] DOUT;
  logic             VLD;
  logic             FE;
  logic             OVR;
  logic             BUSY;

  modport slave (
    input  RXD, ACK,
    output DOUT, VLD, FE, OVR, BUSY
  );

  modport master (
    output RXD, ACK,
    input  DOUT, VLD, FE, OVR, BUSY
  );
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input, reset value selectable.
module sync2 #(
  parameter logic RstVal = 1'b1
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      meta <= RstVal;
      q    <= RstVal;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of start/data/stop, level-valid byte handshake,
// one-cycle framing-error pulse and sticky overrun flag.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned Bauds = 115200,
  parameter int unsigned Wdata = 8,
  parameter int unsigned Wstop = 1
) (
  input  logic      CLK,
  input  logic      RSTN,
  uart_rx_if.slave  bus
);

  localparam int unsigned Nticks = nticks(`FCLK, Bauds);
  localparam int unsigned Nhalf  = Nticks / 2;
  localparam int unsigned Wcnt   = $clog2(Nticks);
  localparam int unsigned Widx   = $clog2(Wdata + 1);
  localparam int unsigned Wsidx  = (Wstop > 1) ? $clog2(Wstop) : 1;

  localparam logic [2:0] S_IDLE  = 3'(IDLE);
  localparam logic [2:0] S_START = 3'(START);
  localparam logic [2:0] S_DATA  = 3'(DATA);
  localparam logic [2:0] S_STOP  = 3'(STOP);
  localparam logic [2:0] S_BREAK = 3'(BREAK);

  logic             rxs;
  logic [2:0]       state, state_nxt;
  logic [Wcnt-1:0]  cnt, cnt_nxt;
  logic [Widx-1:0]  idx, idx_nxt;
  logic [Wsidx-1:0] sidx, sidx_nxt;
  logic [Wdata-1:0] shreg, shreg_nxt;
  logic [Wdata-1:0] dout_q, dout_nxt;
  logic             vld_q, vld_nxt;
  logic             ovr_q, ovr_nxt;
  logic             fe_q;
  logic             busy_q;
  logic             sample_c;
  logic             deliver_c;
  logic             fe_c;

  sync2 #(.RstVal(1'b1)) u_sync (
    .CLK  (CLK),
    .RSTN (RSTN),
    .d    (bus.RXD),
    .q    (rxs)
  );

  assign sample_c = (cnt == '0);

  // Next state, tick counter, shift register and handshake updates.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    sidx_nxt  = sidx;
    shreg_nxt = shreg;
    deliver_c = 1'b0;
    fe_c      = 1'b0;
    dout_nxt  = dout_q;
    vld_nxt   = vld_q;
    ovr_nxt   = ovr_q;

    if (cnt != '0) cnt_nxt = cnt - 1'b1;

    case (state)
      S_IDLE: begin
        if (!rxs) begin
          state_nxt = S_START;
          cnt_nxt   = Wcnt'(Nhalf - 1);
        end
      end
      S_START: begin
        if (sample_c) begin
          if (rxs) begin
            state_nxt = S_IDLE;
          end else begin
            state_nxt = S_DATA;
            idx_nxt   = '0;
            cnt_nxt   = Wcnt'(Nticks - 1);
          end
        end
      end
      S_DATA: begin
        if (sample_c) begin
          for (int i = 0; i < int'(Wdata); i++) begin
            if (idx == Widx'(i)) shreg_nxt[i] = rxs;
          end
          cnt_nxt = Wcnt'(Nticks - 1);
          if (idx == Widx'(Wdata - 1)) begin
            state_nxt = S_STOP;
            sidx_nxt  = '0;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      S_STOP: begin
        if (sample_c) begin
          if (!rxs) begin
            fe_c      = 1'b1;
            state_nxt = S_BREAK;
          end else if (sidx == Wsidx'(Wstop - 1)) begin
            deliver_c = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            sidx_nxt = sidx + 1'b1;
            cnt_nxt  = Wcnt'(Nticks - 1);
          end
        end
      end
      S_BREAK: begin
        if (rxs) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // A delivery coinciding with ACK keeps VLD set and leaves OVR alone.
    if (deliver_c) begin
      dout_nxt = shreg;
      vld_nxt  = 1'b1;
      ovr_nxt  = ovr_q | (vld_q & ~bus.ACK);
    end else if (bus.ACK && vld_q) begin
      vld_nxt = 1'b0;
      ovr_nxt = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state  <= S_IDLE;
      cnt    <= '0;
      idx    <= '0;
      sidx   <= '0;
      shreg  <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
      ovr_q  <= 1'b0;
      fe_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      idx    <= idx_nxt;
      sidx   <= sidx_nxt;
      shreg  <= shreg_nxt;
      dout_q <= dout_nxt;
      vld_q  <= vld_nxt;
      ovr_q  <= ovr_nxt;
      fe_q   <= fe_c;
      busy_q <= (state_nxt != S_IDLE);
    end
  end

  assign bus.DOUT = dout_q;
  assign bus.VLD  = vld_q;
  assign bus.FE   = fe_q;
  assign bus.OVR  = ovr_q;
  assign bus.BUSY = busy_q;

endmodule
